// File: rtl/ldst_pkg.sv
// Shared types for the load path.
//   ld_size_t  : load size selector (word, zero-extended byte, sign-extended byte)
//   ld_entry_t : per-load bookkeeping held while the memory read is outstanding
//   REG_PC     : register index that is never written through the load port
package ldst_pkg;

  typedef enum logic [1:0] {
    LD_WORD  = 2'd0,
    LD_UBYTE = 2'd1,
    LD_SBYTE = 2'd2
  } ld_size_t;

  typedef struct packed {
    logic [3:0] rd;
    ld_size_t   size;
    logic [1:0] off;
  } ld_entry_t;

  localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/ld_fifo.sv
// In-order queue of outstanding loads.
//   clk, rst_n   : clock, synchronous active-low reset (empties the queue)
//   push_i       : write push_data_i at the tail (caller guarantees not full)
//   pop_i        : drop the head entry (caller guarantees not empty)
//   head_o       : oldest entry
//   count_o      : number of valid entries, 0..DEPTH
//   entries_o    : raw storage, indexed by slot
//   valid_o      : per-slot valid bit, used to build the pending-register mask
module ld_fifo
  import ldst_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  ld_entry_t                  push_data_i,
  input  logic                       pop_i,
  output ld_entry_t                  head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output ld_entry_t [DEPTH-1:0]      entries_o,
  output logic [DEPTH-1:0]           valid_o
);

  localparam int PW = $clog2(DEPTH);

  ld_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW:0]           count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d;

  // Pointers wrap for free because DEPTH is a power of two. Push and pop can
  // never target the same slot in one cycle: that would need the queue to be
  // both empty (for the push) and non-empty (for the pop).
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    valid_d = valid_q;
    if (pop_i) begin
      rptr_d          = rptr_q + 1'b1;
      valid_d[rptr_q] = 1'b0;
    end
    if (push_i) begin
      wptr_d          = wptr_q + 1'b1;
      valid_d[wptr_q] = 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= push_data_i;
  end

  assign head_o    = mem_q[rptr_q];
  assign count_o   = count_q;
  assign entries_o = mem_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/load_writeback_unit.sv
// Tracks outstanding data-memory loads and drives the regfile load write port.
//   clk, rst_n                   : clock, synchronous active-low reset
//   req_valid/req_ready          : load request handshake from execute
//   req_addr, req_rd, req_size   : byte address, destination register, size
//   mem_rd_en, mem_addr          : word read to data memory (same cycle as accept)
//   mem_rvalid, mem_rdata        : in-order read responses
//   w_data_ldr/w_addr_ldr/w_en_ldr : registered writeback, one cycle after response
//   pend_mask                    : registers with a load queued or in writeback
//   err                          : sticky, response seen with nothing outstanding
module load_writeback_unit
  import ldst_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_rd,
  input  logic [1:0]        req_size,
  output logic              mem_rd_en,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       w_data_ldr,
  output logic [3:0]        w_addr_ldr,
  output logic              w_en_ldr,
  output logic [15:0]       pend_mask,
  output logic              err
);

  localparam int CW = $clog2(DEPTH);

  logic [CW:0]           count;
  ld_entry_t             head;
  ld_entry_t             push_entry;
  ld_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      ent_vld;
  logic                  accept;
  logic                  pop;

  logic        wb_en_q,   wb_en_d;
  logic [3:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        err_q,     err_d;

  // Byte select is little-endian; word loads ignore the offset entirely.
  function automatic logic [31:0] extract_load(input logic [31:0] data,
                                               input ld_size_t    size,
                                               input logic [1:0]  off);
    logic [7:0] b;
    b = data[8*off +: 8];
    case (size)
      LD_UBYTE: return {24'b0, b};
      LD_SBYTE: return {{24{b[7]}}, b};
      default:  return data;
    endcase
  endfunction

  // Full means not ready, even if a response would free a slot this cycle.
  assign req_ready = (count != (CW+1)'(DEPTH));
  assign accept    = req_valid & req_ready & rst_n;
  assign mem_rd_en = accept;
  assign mem_addr  = req_addr[ADDR_W-1:2];
  assign pop       = mem_rvalid & (count != '0);

  always_comb begin
    push_entry      = '0;
    push_entry.rd   = req_rd;
    push_entry.size = ld_size_t'(req_size);
    push_entry.off  = req_addr[1:0];
  end

  ld_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (accept),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .entries_o   (entries),
    .valid_o     (ent_vld)
  );

  // Writeback register: address/data hold between responses, enable pulses.
  always_comb begin
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    err_d     = err_q | (mem_rvalid & (count == '0));
    if (pop) begin
      wb_en_d   = (head.rd != REG_PC);
      wb_addr_d = head.rd;
      wb_data_d = extract_load(mem_rdata, head.size, head.off);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  // A register stays pending through its writeback cycle so decode never reads
  // the regfile before the load port write has landed.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (entries[i].rd != REG_PC)) pend_mask[entries[i].rd] = 1'b1;
    end
    if (wb_en_q) pend_mask[wb_addr_q] = 1'b1;
  end

  assign w_en_ldr   = wb_en_q;
  assign w_addr_ldr = wb_addr_q;
  assign w_data_ldr = wb_data_q;
  assign err        = err_q;

endmodule
